core_counter: RTL and testbench
===============================

// Module: core_counter
// PURPOSE
//   Hit-driven event counter with a serial status bit. Each rising edge of hit
//   advances a 4-bit event number (NOM). Each NOM wrap advances a 2-bit group
//   counter (BIT).
//   LE is a one-hot lamp-enable decode of BIT. TX is the NOM bit selected by BIT.
//   Standalone lab core: driven by a pushbutton/pulse source (hit), cleared by clr.
// PARAMETERS
//   NOM_W   4   width of event counter (wraps at 2**NOM_W-1)
//   BIT_W   2   width of group counter; LE width = 2**BIT_W
// PORTS
//   hit   in   1   clock; all state advances on its rising edge (single clock)
//   clr   in   1   reset, asynchronous, active-high
//   NOM   out  4   event counter value
//   BIT   out  2   group counter value (number of NOM wraps, modulo 4)
//   LE    out  4   one-hot decode of BIT
//   TX    out  1   serial bit = NOM[BIT]
// BEHAVIOUR
//   Reset
//   - clr=1 forces NOM=0 and BIT=0 immediately, without waiting for a hit edge.
//     As a result LE=4'b0001 and TX=0.
//   - While clr is held, hit edges are ignored.
//   - After clr falls, the first hit rising edge gives NOM=1.
//   Per hit rising edge (clr=0)
//   - NOM <= NOM+1, wrapping 4'hF -> 4'h0.
//   - If NOM==4'hF before the edge, BIT <= BIT+1, wrapping 2'd3 -> 2'd0.
//     NOM and BIT update on the same edge.
//   - Latency: one hit edge to NOM/BIT. LE and TX are combinational from the
//     registers, with no extra cycle.
//   LE mapping
//   - 0 -> 0001, 1 -> 0010, 2 -> 0100, 3 -> 1000.
//   - Exactly one bit is set at all times, including during reset.
//   TX
//   - Combinational mux TX = NOM[BIT]. It updates whenever NOM or BIT changes.
//   Boundaries
//   - 16 hits from reset: NOM=0, BIT=1.
//   - 64 hits: NOM=0, BIT=0 (full wrap).
//   - clr asserted mid-count takes priority over a simultaneous hit edge.
//   - No glitch requirement on TX/LE beyond register settling.
// STRUCTURE
//   - Shared package: NOM_W and BIT_W constants, and the LE one-hot decode
//     function.
//   - One sub-module is natural: core_counter_mod, a generic wrap counter with
//     width, enable and carry-out. Instantiate it twice: NOM with enable=1, and
//     BIT enabled by NOM's carry-out.
//   - Top level adds the LE decode and the TX mux.
// TESTING
//   1. clr=1 then 0, no hits -> NOM=0, BIT=0, LE=0001, TX=0.
//   2. 6 hits -> NOM=6, BIT=0, LE=0001, TX=NOM[0]=0.
//      Add 1 hit -> NOM=7, TX=1.
//   3. 16 hits from reset -> NOM=0, BIT=1, LE=0010.
//      Add 2 hits -> NOM=2, TX=NOM[1]=1.
//   4. 64 hits -> NOM=0, BIT=0 (full wrap).
//      After 70 hits -> NOM=6, BIT=0, LE=0001.
//   5. After 70 hits, assert clr for 6 hit pulses -> NOM=0, BIT=0 throughout.
//      Release clr, then 4 hits -> NOM=4, BIT=0.
//   6. Assert clr asynchronously between hit edges -> outputs clear before the
//      next hit edge. Random hit/clr sequences match a reference model.

Source files
------------

// File: rtl/core_counter_pkg.sv
// Shared constants, types and the lamp-enable decode for the hit-driven event counter.
package core_counter_pkg;

  // Event number width; wraps after 2**NOM_W hits.
  localparam int NOM_W = 4;
  // Group number width; counts event-number wraps.
  localparam int BIT_W = 2;
  // One lamp per group value.
  localparam int LE_W  = 1 << BIT_W;

  typedef logic [NOM_W-1:0] nom_t;
  typedef logic [BIT_W-1:0] bit_t;
  typedef logic [LE_W-1:0]  le_t;

  // One-hot lamp enable: group value g lights lamp g.
  function automatic le_t le_decode(input bit_t grp);
    le_t onehot;
    onehot = '0;
    onehot[grp] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/core_counter_mod.sv
// Generic wrap-around counter with count enable and a carry-out that flags
// the enabled step from all-ones back to zero, so counters can be chained.
module core_counter_mod #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         co
);

  // Count register: cleared immediately by rst, otherwise steps by one when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

  // Carry is combinational so the next stage advances on the very edge this one wraps.
  always_comb begin
    co = en & (&q);
  end

endmodule

// File: rtl/core_counter.sv
// Hit-driven event counter: NOM counts hit edges, BIT counts NOM wraps,
// LE lights one lamp per BIT value and TX exposes the NOM bit picked by BIT.
module core_counter
  import core_counter_pkg::*;
(
  input  logic             hit,
  input  logic             clr,
  output logic [NOM_W-1:0] NOM,
  output logic [BIT_W-1:0] BIT,
  output logic [LE_W-1:0]  LE,
  output logic             TX
);

  logic nom_co;
  logic bit_co;

  // Event counter advances on every hit edge.
  core_counter_mod #(.W(NOM_W)) u_nom (
    .clk (hit),
    .rst (clr),
    .en  (1'b1),
    .q   (NOM),
    .co  (nom_co)
  );

  // Group counter advances only on the edge where the event counter wraps.
  core_counter_mod #(.W(BIT_W)) u_bit (
    .clk (hit),
    .rst (clr),
    .en  (nom_co),
    .q   (BIT),
    .co  (bit_co)
  );

  // Outputs are pure decode of the registers, so they follow NOM/BIT with no extra cycle;
  // the group counter's own carry has no consumer here and is deliberately dropped.
  always_comb begin
    LE = le_decode(BIT);
    TX = NOM[BIT];
  end

  logic unused_ok;
  assign unused_ok = bit_co;

endmodule

// File: tb/tb_core_counter.sv
// Self-checking bench for core_counter: directed boundary walks plus a random
// hit/clr sequence, compared against a hit-count model of the counter.
module tb_core_counter;

  logic       hit;
  logic       clr;
  logic [3:0] NOM;
  logic [1:0] BIT;
  logic [3:0] LE;
  logic       TX;

  int tests_run;
  int tests_failed;
  int hits;   // hit edges accepted since the last clear, modulo 64

  core_counter dut (
    .hit (hit),
    .clr (clr),
    .NOM (NOM),
    .BIT (BIT),
    .LE  (LE),
    .TX  (TX)
  );

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Check every output against the model derived from the hit count.
  task automatic checkModel(input string tag);
    int nom_e, bit_e;
    nom_e = hits % 16;
    bit_e = (hits / 16) % 4;
    checkOutput({tag, ".NOM"}, 32'(NOM), 32'(nom_e));
    checkOutput({tag, ".BIT"}, 32'(BIT), 32'(bit_e));
    checkOutput({tag, ".LE"},  32'(LE),  32'(1 << bit_e));
    checkOutput({tag, ".TX"},  32'(TX),  32'((nom_e >> bit_e) & 1));
  endtask

  // Issue n hit pulses; they count only while clr is low. Outputs are sampled mid-low.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      #5 hit = 1'b1;
      if (!clr) hits = (hits + 1) % 64;
      #5 hit = 1'b0;
    end
  endtask

  // Short asynchronous clear while hit is low.
  task automatic pulseClear();
    #2 clr = 1'b1;
    hits = 0;
    #2 clr = 1'b0;
    #1;
  endtask

  initial begin
    int r;
    tests_run = 0;
    tests_failed = 0;
    hits = 0;
    hit = 1'b0;
    clr = 1'b1;
    #7;
    clr = 1'b0;
    #3;

    // 1: reset state, no hits
    checkOutput("reset.NOM", 32'(NOM), 32'h0);
    checkOutput("reset.BIT", 32'(BIT), 32'h0);
    checkOutput("reset.LE",  32'(LE),  32'h1);
    checkOutput("reset.TX",  32'(TX),  32'h0);

    // 2: six hits then one more
    applyStimulus(6);
    checkOutput("h6.NOM", 32'(NOM), 32'h6);
    checkOutput("h6.TX",  32'(TX),  32'h0);
    checkModel("h6");
    applyStimulus(1);
    checkOutput("h7.NOM", 32'(NOM), 32'h7);
    checkOutput("h7.TX",  32'(TX),  32'h1);

    // 3: sixteen hits from reset, then two more
    pulseClear();
    applyStimulus(16);
    checkOutput("h16.NOM", 32'(NOM), 32'h0);
    checkOutput("h16.BIT", 32'(BIT), 32'h1);
    checkOutput("h16.LE",  32'(LE),  32'h2);
    applyStimulus(2);
    checkOutput("h18.NOM", 32'(NOM), 32'h2);
    checkOutput("h18.TX",  32'(TX),  32'h1);

    // 4: full wrap at 64, then on to 70
    pulseClear();
    applyStimulus(64);
    checkOutput("h64.NOM", 32'(NOM), 32'h0);
    checkOutput("h64.BIT", 32'(BIT), 32'h0);
    checkModel("h64");
    applyStimulus(6);
    checkOutput("h70.NOM", 32'(NOM), 32'h6);
    checkOutput("h70.LE",  32'(LE),  32'h1);

    // 5: hold clr across six hit pulses, then release and count four
    clr = 1'b1;
    hits = 0;
    #1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkModel("hold");
    end
    clr = 1'b0;
    applyStimulus(4);
    checkOutput("rel4.NOM", 32'(NOM), 32'h4);
    checkOutput("rel4.BIT", 32'(BIT), 32'h0);

    // 6a: asynchronous clear between edges from a nonzero group state
    applyStimulus(37);
    checkModel("pre_async");
    #2 clr = 1'b1;
    hits = 0;
    #1;
    checkOutput("async.NOM", 32'(NOM), 32'h0);
    checkOutput("async.BIT", 32'(BIT), 32'h0);
    checkOutput("async.LE",  32'(LE),  32'h1);
    #1 clr = 1'b0;

    // 6b: clr rising together with a hit edge wins
    applyStimulus(20);
    #5;
    clr = 1'b1;
    hit = 1'b1;
    hits = 0;
    #5 hit = 1'b0;
    clr = 1'b0;
    #1;
    checkModel("simul");

    // 6c: random hit/clr mix against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        pulseClear();
      end else if (r == 1) begin
        clr = 1'b1;
        hits = 0;
        applyStimulus(1);
        clr = 1'b0;
      end else begin
        applyStimulus($urandom_range(1, 5));
      end
      checkModel("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
